if_id_queue: RTL

//   Instruction queue between fetch and decode. Buffers fetched {pc, inst, excode}
//   and presents them in order. Decode slices out_inst[15:0] for the immediate

---
 rtl/if_id_queue.sv | 81 ++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: an in-order FIFO of {pc, inst, excode}
// with valid/ready on both sides and a redirect flush that empties it in one cycle.
module if_id_queue #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    input  logic [4:0]                 in_excode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [4:0]                 out_excode,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]  r_pc     [DEPTH];
    logic [31:0]      r_inst   [DEPTH];
    logic [4:0]       r_excode [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Ready depends only on the registered count, so out_ready never reaches in_ready.
    assign in_ready  = (r_count != FULL_COUNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    assign out_pc     = out_valid ? r_pc[r_rd_ptr]     : '0;
    assign out_inst   = out_valid ? r_inst[r_rd_ptr]   : '0;
    assign out_excode = out_valid ? r_excode[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; a write during flush is harmless because the pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]     <= in_pc;
            r_inst[r_wr_ptr]   <= in_inst;
            r_excode[r_wr_ptr] <= in_excode;
        end
    end

endmodule
